writeback_scheduler: RTL
========================

# writeback_scheduler

Controls the single write port of the 32 x XLEN general purpose register file, sharing it between several writeback requesters (ALU, LSU, MUL/DIV) with round-robin arbitration. It also keeps a per-register busy scoreboard: the decoder reserves a destination at issue, and the scheduler flags read-after-write hazards until the write is visible in the register file. The block sits between the execution units and the register file's write address and write value inputs. A write address of 0 means "no write".

## Interface
- XLEN, 32 (from imhotep_pkg): data width.
- NUM_REQ, 3: number of writeback requesters. Index 0 = ALU, 1 = LSU, 2 = MUL/DIV.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  requester k holds a result.
- req_addr_i  input  NUM_REQ*5  destination register, requester k at bits [5k+4:5k].
- req_value_i  input  NUM_REQ*XLEN  result value, requester k at bits [XLEN*k+XLEN-1:XLEN*k].
- req_ready_o  output  NUM_REQ  one-hot grant (combinational); a transfer happens when valid and ready are both high.
- issue_valid_i  input  1  decoder reserves a destination.
- issue_rd_i  input  5  destination register to reserve.
- issue_ready_o  output  1  reservation accepted.
- r1_addr_i, r2_addr_i  input  5 each  decoder source registers.
- hazard_o  output  1  a source register is not yet readable.
- w_addr_o  output  5  register file write address (registered).
- w_value_o  output  XLEN  register file write value (registered).
- busy_o  output  32  scoreboard bits. Bit 0 is always 0.

## Operation
**Arbitration**
- A round-robin pointer `ptr` (0..NUM_REQ-1) marks the highest-priority requester.
- The grant goes to the first valid requester scanning ptr, ptr+1, … (mod NUM_REQ).
- After a grant to k, ptr becomes (k+1) mod NUM_REQ. With no grant, ptr holds.
- At most one grant per cycle. req_ready_o is 0 for requesters that are not valid.

**Write port**
- On a grant, w_addr_o and w_value_o load the granted address and value at the next edge.
- With no grant, w_addr_o loads 0 and w_value_o holds its value.
- A request to x0 is granted and consumed, and produces w_addr_o = 0.

**Scoreboard**
- issue_ready_o = issue_valid_i & !busy[issue_rd_i]. Reserving an already-busy register stalls (WAW protection).
- On accept with issue_rd_i ≠ 0, busy[issue_rd_i] is set.
- Issue to x0 is always accepted and sets nothing.
- A grant clears busy[req_addr]. A grant to a register that is not busy leaves the scoreboard unchanged.

**Hazard**
- For each source s in {r1, r2}, s ≠ 0 raises hazard_o if busy[s] = 1, or if w_addr_o == s (the write has not landed yet).

## Timing
- Grant in cycle N → w_addr_o/w_value_o valid in N+1 → register file stores at the end of N+1 → the value is readable in N+2.
- The busy bit clears at the end of N. The w_addr_o match keeps hazard_o high through N+1.
- Issue accepted in M → busy set at the end of M → hazard_o visible from M+1.
- hazard_o reflects registered state only; a same-cycle issue does not affect it.
- Simultaneous grant (clear) and issue on the same rd cannot occur, because issue_ready_o is low while busy.
- Issue to rd in N+1, while the old write to rd is still on w_addr_o, is legal. The old write lands first.
- Reset values: ptr = 0, busy = 0, w_addr_o = 0, w_value_o = 0.
- While reset is high: req_ready_o = 0 and issue_ready_o = 0.
- Reset mid-operation drops all pending grants and reservations. Requesters must re-present their results.

## Configuration
- WB_BYPASS_EN defined:
  - adds output ports r1_fwd_o and r2_fwd_o (XLEN each), equal to w_value_o when the source address == w_addr_o ≠ 0, and 0 otherwise;
  - a w_addr_o match no longer raises hazard_o, only busy does.
  - Net effect: write-to-use latency drops by one cycle.
- Not defined: no forwarding ports; the w_addr_o match raises hazard_o as described above.

## Test plan
- **Round-robin:** all three requesters valid continuously with addresses 5/6/7 → grants in order 0,1,2,0; w_addr_o sequence 5,6,7,5, one cycle after each grant.
- **Scoreboard:**
  - issue rd = 9 in cycle 0;
  - r1_addr_i = 9 gives hazard_o = 1 from cycle 1;
  - LSU writes x9 = 0xDEADBEEF, granted in cycle 4;
  - hazard_o stays 1 in cycle 5 and is 0 in cycle 6 (with WB_BYPASS_EN: 0 in cycle 5, with r1_fwd_o = 0xDEADBEEF).
- **WAW stall:** issue rd = 3 twice back to back → second issue_ready_o = 0 until the x3 write is granted, then 1 the following cycle.
- **x0 handling:**
  - issue rd = 0 → accepted, busy_o stays 0;
  - request to x0 → granted, w_addr_o = 0;
  - r1_addr_i = 0 never raises hazard.
- **Reset mid-operation:** busy = 0x0000_0600 and requests pending; assert reset for one cycle → busy_o = 0, w_addr_o = 0, req_ready_o = 0 during reset, ptr restarts at requester 0.

Source files
------------

// File: rtl/writeback_scheduler.sv
// writeback_scheduler: shares the single register-file write port between the
// ALU, LSU and MUL/DIV writeback requesters with round-robin arbitration. It
// also keeps a per-register busy scoreboard for read-after-write hazard
// detection.
// Optional feature macro: WB_BYPASS_EN adds forwarding from the registered
// write port and removes the write-port term from hazard_o.
module writeback_scheduler #(
    parameter int XLEN    = 32,   // matches imhotep_pkg::XLEN
    parameter int NUM_REQ = 3     // 0 = ALU, 1 = LSU, 2 = MUL/DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_addr_i,
    input  logic [NUM_REQ*XLEN-1:0] req_value_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic                    issue_valid_i,
    input  logic [4:0]              issue_rd_i,
    output logic                    issue_ready_o,
    input  logic [4:0]              r1_addr_i,
    input  logic [4:0]              r2_addr_i,
    output logic                    hazard_o,
`ifdef WB_BYPASS_EN
    output logic [XLEN-1:0]         r1_fwd_o,
    output logic [XLEN-1:0]         r2_fwd_o,
`endif
    output logic [4:0]              w_addr_o,
    output logic [XLEN-1:0]         w_value_o,
    output logic [31:0]             busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [31:0]      busy;
    logic             grant_any;
    int               grant_idx;
    int               cand;
    logic [4:0]       grant_addr;
    logic [XLEN-1:0]  grant_value;
    logic [31:0]      busy_clr;
    logic [31:0]      busy_set;
    logic             r1_haz;
    logic             r2_haz;

    // Round-robin arbiter: first valid requester scanning from ptr upward.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_ready_o = '0;
        grant_any   = 1'b0;
        grant_idx   = 0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!grant_any && req_valid_i[cand]) begin
                req_ready_o[cand] = 1'b1;
                grant_any         = 1'b1;
                grant_idx         = cand;
            end
        end
        // Reset suppresses all grants so nothing is consumed and then lost.
        if (reset) begin
            req_ready_o = '0;
            grant_any   = 1'b0;
        end
    end

    assign grant_addr  = req_addr_i[grant_idx*5 +: 5];
    assign grant_value = req_value_i[grant_idx*XLEN +: XLEN];

    // A reservation only succeeds on an idle register (WAW protection); x0 is never busy.
    assign issue_ready_o = issue_valid_i && !busy[issue_rd_i] && !reset;

    // Scoreboard edits for this cycle: clear on grant, set on accepted issue.
    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (grant_any) begin
            busy_clr = 32'd1 << grant_addr;
        end
        if (issue_ready_o && (issue_rd_i != 5'd0)) begin
            busy_set = 32'd1 << issue_rd_i;
        end
    end

    // Pointer, scoreboard and registered write port.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            busy      <= '0;
            w_addr_o  <= '0;
            w_value_o <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
            if (grant_any) begin
                ptr       <= PTR_W'((grant_idx + 1) % NUM_REQ);
                w_addr_o  <= grant_addr;
                w_value_o <= grant_value;
            end else begin
                w_addr_o  <= 5'd0;
            end
        end
    end

    assign busy_o = {busy[31:1], 1'b0};

    // Hazard per source: busy, or (without bypass) the write is still on the port.
    always_comb begin
`ifdef WB_BYPASS_EN
        r1_haz   = (r1_addr_i != 5'd0) && busy[r1_addr_i];
        r2_haz   = (r2_addr_i != 5'd0) && busy[r2_addr_i];
        r1_fwd_o = ((r1_addr_i != 5'd0) && (r1_addr_i == w_addr_o)) ? w_value_o : '0;
        r2_fwd_o = ((r2_addr_i != 5'd0) && (r2_addr_i == w_addr_o)) ? w_value_o : '0;
`else
        r1_haz   = (r1_addr_i != 5'd0) && (busy[r1_addr_i] || (w_addr_o == r1_addr_i));
        r2_haz   = (r2_addr_i != 5'd0) && (busy[r2_addr_i] || (w_addr_o == r2_addr_i));
`endif
        hazard_o = r1_haz || r2_haz;
    end

endmodule
